// File: rtl/pc_gen_if.sv
// Fetch-PC stream between the PC generator and the instruction fetch unit.
// AXI-Stream style valid/ready handshake carrying one fetch address per beat.
interface pc_gen_if #(
    parameter int unsigned XLEN = 32
);
    logic            tvalid;
    logic            tready;
    logic [XLEN-1:0] tdata;

    modport master (
        output tvalid,
        output tdata,
        input  tready
    );

    modport slave (
        input  tvalid,
        input  tdata,
        output tready
    );
endinterface

// File: rtl/pc_gen.sv
// Program counter generator: issues sequential fetch PCs, takes back-end redirects
// (flushing the front end), supports a halt handshake and counts accepted fetches.
module pc_gen #(
    parameter int unsigned        XLEN         = 32,
    parameter logic [XLEN-1:0]    RESET_VECTOR = {XLEN{1'b0}},
    parameter int unsigned        INST_BYTES   = 4
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            redirect_valid,
    input  logic [XLEN-1:0] redirect_pc,
    input  logic            halt_req,
    output logic            halt_ack,
    pc_gen_if.master        pcg,
    output logic            invalidate,
    output logic [63:0]     fetch_count
);

    localparam logic [1:0] BOOT  = 2'd0;
    localparam logic [1:0] RUN   = 2'd1;
    localparam logic [1:0] FLUSH = 2'd2;
    localparam logic [1:0] HALT  = 2'd3;

    localparam logic [XLEN-1:0] INST_STEP = XLEN'(INST_BYTES);

    // Redirect targets are word aligned regardless of what the back end sends.
    function automatic logic [XLEN-1:0] align_pc(input logic [XLEN-1:0] pc);
        return {pc[XLEN-1:2], 2'b00};
    endfunction

    function automatic logic [XLEN-1:0] seq_pc(input logic [XLEN-1:0] pc);
        return pc + INST_STEP;
    endfunction

    logic [1:0]      state_r;
    logic [1:0]      state_nxt_s;
    logic [XLEN-1:0] pc_r;
    logic [XLEN-1:0] pc_nxt_s;
    logic [63:0]     count_r;
    logic [63:0]     count_nxt_s;
    logic            tvalid_r;
    logic            invalidate_r;
    logic            halt_ack_r;
    logic            beat_s;

    assign beat_s = tvalid_r & pcg.tready;

    // Next-state, next-PC and fetch counter; redirect outranks every state transition.
    always_comb begin
        state_nxt_s = state_r;
        pc_nxt_s    = pc_r;
        count_nxt_s = count_r;

        if (beat_s) begin
            count_nxt_s = count_r + 64'd1;
            pc_nxt_s    = seq_pc(pc_r);
        end else begin
            count_nxt_s = count_r;
            pc_nxt_s    = pc_r;
        end

        if (redirect_valid) begin
            state_nxt_s = FLUSH;
            pc_nxt_s    = align_pc(redirect_pc);
        end else begin
            case (state_r)
                BOOT: begin
                    if (halt_req) begin
                        state_nxt_s = HALT;
                    end else begin
                        state_nxt_s = RUN;
                    end
                end
                RUN: begin
                    // Halt only takes effect on a beat so a presented PC is never withdrawn.
                    if (beat_s && halt_req) begin
                        state_nxt_s = HALT;
                    end else begin
                        state_nxt_s = RUN;
                    end
                end
                FLUSH: begin
                    if (halt_req) begin
                        state_nxt_s = HALT;
                    end else begin
                        state_nxt_s = RUN;
                    end
                end
                HALT: begin
                    if (halt_req) begin
                        state_nxt_s = HALT;
                    end else begin
                        state_nxt_s = RUN;
                    end
                end
                default: begin
                    state_nxt_s = BOOT;
                end
            endcase
        end
    end

    // State, PC, counter and outputs; outputs are decoded from the next state and registered.
    always_ff @(posedge clk) begin
        if (!rst) begin
            state_r      <= BOOT;
            pc_r         <= RESET_VECTOR;
            count_r      <= 64'd0;
            tvalid_r     <= 1'b0;
            invalidate_r <= 1'b0;
            halt_ack_r   <= 1'b0;
        end else begin
            state_r      <= state_nxt_s;
            pc_r         <= pc_nxt_s;
            count_r      <= count_nxt_s;
            tvalid_r     <= (state_nxt_s == RUN);
            invalidate_r <= (state_nxt_s == FLUSH);
            halt_ack_r   <= (state_nxt_s == HALT);
        end
    end

    assign pcg.tvalid  = tvalid_r;
    assign pcg.tdata   = pc_r;
    assign invalidate  = invalidate_r;
    assign halt_ack    = halt_ack_r;
    assign fetch_count = count_r;

endmodule

// File: tb/tb_pc_gen.sv
// Self-checking bench for pc_gen: expected PCs are queued as stimulus is driven
// and popped when the DUT presents them; a second instance exercises PC wrap.
module tb_pc_gen;

    logic        clk;
    logic        rst;
    logic        redirect_valid;
    logic [31:0] redirect_pc;
    logic        halt_req;
    logic        halt_ack;
    logic        invalidate;
    logic [63:0] fetch_count;
    logic        halt_ack_w;
    logic        invalidate_w;
    logic [63:0] fetch_count_w;

    int          vectors;
    int          miscompares;
    logic [31:0] exp_q[$];
    logic [31:0] exp_pc;
    logic [63:0] exp_count;
    logic [63:0] exp_count_w;

    pc_gen_if #(.XLEN(32)) pcg();
    pc_gen_if #(.XLEN(32)) pcg_w();

    pc_gen #(.XLEN(32), .RESET_VECTOR(32'h0000_0000), .INST_BYTES(4)) dut (
        .clk(clk), .rst(rst), .redirect_valid(redirect_valid), .redirect_pc(redirect_pc),
        .halt_req(halt_req), .halt_ack(halt_ack), .pcg(pcg.master),
        .invalidate(invalidate), .fetch_count(fetch_count)
    );

    pc_gen #(.XLEN(32), .RESET_VECTOR(32'hFFFF_FFFC), .INST_BYTES(4)) dut_wrap (
        .clk(clk), .rst(rst), .redirect_valid(redirect_valid), .redirect_pc(redirect_pc),
        .halt_req(halt_req), .halt_ack(halt_ack_w), .pcg(pcg_w.master),
        .invalidate(invalidate_w), .fetch_count(fetch_count_w)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic test_reset();
        rst = 1'b0; redirect_valid = 1'b0; redirect_pc = 32'h0; halt_req = 1'b0;
        pcg.tready = 1'b0; pcg_w.tready = 1'b0;
        repeat (2) @(negedge clk);
        vectors++;
        if ({pcg.tvalid, invalidate, halt_ack} !== 3'b000) begin
            miscompares++;
            $display("FAIL reset_flags: got %b expected 000", {pcg.tvalid, invalidate, halt_ack});
        end
        vectors++;
        if (fetch_count !== 64'd0 || pcg.tdata !== 32'h0) begin
            miscompares++;
            $display("FAIL reset_state: got count=%0d pc=%h expected 0/00000000", fetch_count, pcg.tdata);
        end
        rst = 1'b1;
        exp_q.delete();
        exp_count = 64'd0;
        exp_pc = 32'h0;
    endtask

    task automatic test_sequential();
        int beats = 0;
        for (int i = 0; i < 8; i++) exp_q.push_back(32'h0 + 32'(4 * i));
        pcg.tready = 1'b1;
        for (int c = 0; c < 20; c++) begin
            @(negedge clk);
            if (exp_q.size() == 0) break;
            vectors++;
            if (fetch_count !== exp_count) begin
                miscompares++;
                $display("FAIL seq_count: got %0d expected %0d", fetch_count, exp_count);
            end
            vectors++;
            if (pcg.tvalid !== 1'b1 || pcg.tdata !== exp_q[0]) begin
                miscompares++;
                $display("FAIL seq_pc: got valid=%b pc=%h expected 1/%h", pcg.tvalid, pcg.tdata, exp_q[0]);
            end
            void'(exp_q.pop_front());
            exp_count++;
            beats++;
        end
        pcg.tready = 1'b0;
        exp_pc = 32'h20;
        vectors++;
        if (beats != 8 || exp_q.size() != 0) begin
            miscompares++;
            $display("FAIL seq_rate: got %0d beats expected 8", beats);
            exp_q.delete();
        end
    endtask

    task automatic test_backpressure();
        logic [3:0] pat = 4'b1001;
        for (int i = 0; i < 3; i++) exp_q.push_back(exp_pc + 32'(4 * i));
        for (int c = 0; c < 12; c++) begin
            @(negedge clk);
            if (exp_q.size() == 0) break;
            pcg.tready = pat[3 - (c % 4)];
            vectors++;
            if (pcg.tvalid !== 1'b1 || pcg.tdata !== exp_q[0] || fetch_count !== exp_count) begin
                miscompares++;
                $display("FAIL bp_hold: got valid=%b pc=%h count=%0d expected 1/%h/%0d",
                         pcg.tvalid, pcg.tdata, fetch_count, exp_q[0], exp_count);
            end
            if (pcg.tready) begin
                void'(exp_q.pop_front());
                exp_count++;
            end
        end
        pcg.tready = 1'b0;
        vectors++;
        if (exp_q.size() != 0) begin
            miscompares++;
            $display("FAIL bp_timeout: got %0d pending expected 0", exp_q.size());
            exp_q.delete();
        end
        exp_pc = exp_pc + 32'd12;
    endtask

    task automatic test_redirect();
        @(negedge clk);
        vectors++;
        if (pcg.tvalid !== 1'b1 || pcg.tdata !== exp_pc) begin
            miscompares++;
            $display("FAIL redir_pre: got valid=%b pc=%h expected 1/%h", pcg.tvalid, pcg.tdata, exp_pc);
        end
        pcg.tready = 1'b1; redirect_valid = 1'b1; redirect_pc = 32'h8000_0003;
        exp_count++;
        exp_q.push_back(32'h8000_0000);
        @(negedge clk);
        redirect_valid = 1'b0; pcg.tready = 1'b0;
        vectors++;
        if (invalidate !== 1'b1 || pcg.tvalid !== 1'b0 || fetch_count !== exp_count) begin
            miscompares++;
            $display("FAIL redir_flush: got inv=%b valid=%b count=%0d expected 1/0/%0d",
                     invalidate, pcg.tvalid, fetch_count, exp_count);
        end
        @(negedge clk);
        vectors++;
        if (invalidate !== 1'b0 || pcg.tvalid !== 1'b1 || pcg.tdata !== exp_q[0]) begin
            miscompares++;
            $display("FAIL redir_target: got inv=%b valid=%b pc=%h expected 0/1/%h",
                     invalidate, pcg.tvalid, pcg.tdata, exp_q[0]);
        end
        exp_pc = exp_q.pop_front();
    endtask

    task automatic test_back_to_back();
        @(negedge clk);
        redirect_valid = 1'b1; redirect_pc = 32'h0000_0100;
        @(negedge clk);
        vectors++;
        if (invalidate !== 1'b1 || pcg.tvalid !== 1'b0) begin
            miscompares++;
            $display("FAIL b2b_first: got inv=%b valid=%b expected 1/0", invalidate, pcg.tvalid);
        end
        redirect_pc = 32'h0000_0200;
        exp_q.push_back(32'h0000_0200);
        @(negedge clk);
        redirect_valid = 1'b0;
        vectors++;
        if (invalidate !== 1'b1 || pcg.tvalid !== 1'b0) begin
            miscompares++;
            $display("FAIL b2b_second: got inv=%b valid=%b expected 1/0", invalidate, pcg.tvalid);
        end
        @(negedge clk);
        vectors++;
        if (invalidate !== 1'b0 || pcg.tvalid !== 1'b1 || pcg.tdata !== exp_q[0]) begin
            miscompares++;
            $display("FAIL b2b_target: got inv=%b valid=%b pc=%h expected 0/1/%h",
                     invalidate, pcg.tvalid, pcg.tdata, exp_q[0]);
        end
        exp_pc = exp_q.pop_front() + 32'd4;
        pcg.tready = 1'b1;
        exp_count++;
    endtask

    task automatic test_halt();
        @(negedge clk);
        pcg.tready = 1'b0; halt_req = 1'b1;
        for (int c = 0; c < 5; c++) begin
            @(negedge clk);
            vectors++;
            if (pcg.tvalid !== 1'b1 || halt_ack !== 1'b0 || pcg.tdata !== exp_pc) begin
                miscompares++;
                $display("FAIL halt_stall: got valid=%b ack=%b pc=%h expected 1/0/%h",
                         pcg.tvalid, halt_ack, pcg.tdata, exp_pc);
            end
        end
        pcg.tready = 1'b1;
        exp_count++;
        exp_q.push_back(exp_pc + 32'd4);
        for (int c = 0; c < 2; c++) begin
            @(negedge clk);
            vectors++;
            if (halt_ack !== 1'b1 || pcg.tvalid !== 1'b0 || fetch_count !== exp_count) begin
                miscompares++;
                $display("FAIL halt_ack: got ack=%b valid=%b count=%0d expected 1/0/%0d",
                         halt_ack, pcg.tvalid, fetch_count, exp_count);
            end
        end
        halt_req = 1'b0; pcg.tready = 1'b0;
        @(negedge clk);
        vectors++;
        if (halt_ack !== 1'b0 || pcg.tvalid !== 1'b1 || pcg.tdata !== exp_q[0]) begin
            miscompares++;
            $display("FAIL halt_resume: got ack=%b valid=%b pc=%h expected 0/1/%h",
                     halt_ack, pcg.tvalid, pcg.tdata, exp_q[0]);
        end
        exp_pc = exp_q.pop_front();
    endtask

    task automatic test_wrap();
        rst = 1'b0; pcg.tready = 1'b0; pcg_w.tready = 1'b0;
        repeat (2) @(negedge clk);
        rst = 1'b1; pcg_w.tready = 1'b1;
        exp_count = 64'd0; exp_count_w = 64'd0; exp_pc = 32'h0;
        exp_q.push_back(32'hFFFF_FFFC);
        exp_q.push_back(32'h0000_0000);
        @(negedge clk);
        vectors++;
        if (pcg_w.tvalid !== 1'b1 || pcg_w.tdata !== exp_q[0]) begin
            miscompares++;
            $display("FAIL wrap_first: got valid=%b pc=%h expected 1/%h", pcg_w.tvalid, pcg_w.tdata, exp_q[0]);
        end
        void'(exp_q.pop_front());
        exp_count_w++;
        @(negedge clk);
        pcg_w.tready = 1'b0;
        vectors++;
        if (pcg_w.tdata !== exp_q[0] || fetch_count_w !== exp_count_w) begin
            miscompares++;
            $display("FAIL wrap_zero: got pc=%h count=%0d expected %h/%0d",
                     pcg_w.tdata, fetch_count_w, exp_q[0], exp_count_w);
        end
        void'(exp_q.pop_front());
    endtask

    task automatic test_reset_in_flush();
        @(negedge clk);
        pcg.tready = 1'b1;
        exp_count++;
        @(negedge clk);
        pcg.tready = 1'b0; redirect_valid = 1'b1; redirect_pc = 32'h0000_0040;
        @(negedge clk);
        redirect_valid = 1'b0; rst = 1'b0;
        vectors++;
        if (invalidate !== 1'b1 || fetch_count !== exp_count) begin
            miscompares++;
            $display("FAIL rstf_flush: got inv=%b count=%0d expected 1/%0d", invalidate, fetch_count, exp_count);
        end
        exp_count = 64'd0;
        exp_q.push_back(32'h0000_0000);
        @(negedge clk);
        rst = 1'b1;
        vectors++;
        if ({pcg.tvalid, invalidate, halt_ack} !== 3'b000 || fetch_count !== exp_count) begin
            miscompares++;
            $display("FAIL rstf_boot: got flags=%b count=%0d expected 000/0",
                     {pcg.tvalid, invalidate, halt_ack}, fetch_count);
        end
        @(negedge clk);
        vectors++;
        if (pcg.tvalid !== 1'b1 || pcg.tdata !== exp_q[0]) begin
            miscompares++;
            $display("FAIL rstf_vector: got valid=%b pc=%h expected 1/%h", pcg.tvalid, pcg.tdata, exp_q[0]);
        end
        void'(exp_q.pop_front());
    endtask

    initial begin
        vectors = 0;
        miscompares = 0;
        test_reset();
        test_sequential();
        test_backpressure();
        test_redirect();
        test_back_to_back();
        test_halt();
        test_wrap();
        test_reset_in_flush();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
